ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 16-bit word RAM between two requesters: port A (processor load/store and fetch) and port B (loader/debug DMA). It performs one RAM access per cycle, selects a winner by round-robin or fixed priority, and supports a bus lock for atomic read-modify-write sequences, with a lock timeout. It steers the winner's address, write data and write enable to the RAM and returns read data with the RAM's one-cycle registered read latency.

---
 rtl/ram_arbiter_if.sv | 52 +++++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Purpose : bundle of the two requester ports, the RAM port and the lock error flag of ram_arbiter.
// Latency : none; only wires.
// Backpressure: gnt is the accept signal; a requester holds req and its command until gnt is seen.
// Ports (slave = arbiter side): a_*/b_* request, command and read-return signals,
//   mem_* RAM address/data/write-enable with mem_dout read data, lock_err forced-release pulse.
interface ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          a_req;
    logic          a_we;
    logic          a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic          b_lock;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

    logic          lock_err;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  mem_dout,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output lock_err, mem_addr, mem_din, mem_we
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output mem_dout,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  lock_err, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/ram_arbiter.sv
// Purpose : shares one single-port registered-read RAM between ports A and B, with bus lock and lock timeout.
// Latency : grant and mem_* combinational from req; read data/rvalid one cycle after the granted read.
// Backpressure: a losing or locked-out port sees gnt=0 and must hold req and its command.
// Ports: clk, rst_n (synchronous, active low); bus (slave modport) carries both requester
//   ports, the RAM port and lock_err. FIXED_PRI=1 gives A priority, else round-robin.
//   LOCK_MAX bounds consecutive locked cycles before a forced release.
module ram_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int FIXED_PRI = 0,
    parameter int LOCK_MAX  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {ARB, LOCK_A, LOCK_B} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;          // 1: B was granted most recently
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          a_ban_q, a_ban_d;
    logic          b_ban_q, b_ban_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic          lock_err_q, lock_err_d;

    logic          a_gnt, b_gnt;
    logic          a_lock_eff, b_lock_eff;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;

    // A port that timed out cannot take the lock again until it drops lock once.
    assign a_lock_eff = bus.a_lock & ~a_ban_q;
    assign b_lock_eff = bus.b_lock & ~b_ban_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = '0;
        a_ban_d    = a_ban_q;
        b_ban_d    = b_ban_q;
        lock_err_d = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;

        case (state_q)
            ARB: begin
                if (bus.a_req && (!bus.b_req || FIXED_PRI != 0 || last_q)) begin
                    a_gnt = 1'b1;
                end else if (bus.b_req) begin
                    b_gnt = 1'b1;
                end
                if (a_gnt) begin
                    last_d = 1'b0;
                    if (a_lock_eff) state_d = LOCK_A;
                end
                if (b_gnt) begin
                    last_d = 1'b1;
                    if (b_lock_eff) state_d = LOCK_B;
                end
            end
            LOCK_A: begin
                a_gnt = bus.a_req;
                if (a_gnt) last_d = 1'b0;
                if (!bus.a_lock) begin
                    // Final access (if any) is granted in this same cycle.
                    state_d = ARB;
                end else if (lock_cnt_q == CNT_LAST) begin
                    // Timeout: hand the next contention to the other port.
                    state_d    = ARB;
                    lock_err_d = 1'b1;
                    a_ban_d    = 1'b1;
                    last_d     = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end
            LOCK_B: begin
                b_gnt = bus.b_req;
                if (b_gnt) last_d = 1'b1;
                if (!bus.b_lock) begin
                    state_d = ARB;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d    = ARB;
                    lock_err_d = 1'b1;
                    b_ban_d    = 1'b1;
                    last_d     = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end
            default: state_d = ARB;
        endcase

        if (!bus.a_lock) a_ban_d = 1'b0;
        if (!bus.b_lock) b_ban_d = 1'b0;

        // No access may reach the RAM while reset is held.
        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end

        a_rvalid_d = a_gnt & ~bus.a_we;
        b_rvalid_d = b_gnt & ~bus.b_we;
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (a_gnt) begin
            mem_addr = bus.a_addr;
            mem_din  = bus.a_wdata;
            mem_we   = bus.a_we;
        end else if (b_gnt) begin
            mem_addr = bus.b_addr;
            mem_din  = bus.b_wdata;
            mem_we   = bus.b_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            a_ban_q    <= 1'b0;
            b_ban_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            a_ban_q    <= a_ban_d;
            b_ban_q    <= b_ban_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    // Masking with rst_n discards a read that returns in a cycle where reset is asserted.
    assign bus.a_rvalid = a_rvalid_q & rst_n;
    assign bus.b_rvalid = b_rvalid_q & rst_n;
    assign bus.a_rdata  = bus.mem_dout;
    assign bus.b_rdata  = bus.mem_dout;
    assign bus.lock_err = lock_err_q;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;
    assign bus.mem_we   = mem_we;
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int LOCK_MAX0 = 4;

    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(16), .DW(16)) if0 ();
    ram_arbiter_if #(.AW(16), .DW(16)) if1 ();

    ram_arbiter #(.AW(16), .DW(16), .FIXED_PRI(0), .LOCK_MAX(LOCK_MAX0)) u_rr (
        .clk(clk), .rst_n(rst0), .bus(if0)
    );
    ram_arbiter #(.AW(16), .DW(16), .FIXED_PRI(1), .LOCK_MAX(16)) u_fp (
        .clk(clk), .rst_n(rst1), .bus(if1)
    );

    // Registered-read RAMs, initial content A000+index.
    logic [15:0] ram0 [256];
    logic [15:0] ram1 [256];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram0[i] <= 16'hA000 + 16'(i);
            ram1[i] <= 16'hA000 + 16'(i);
        end
    end
    always @(posedge clk) begin
        if (if0.mem_we) ram0[if0.mem_addr[7:0]] <= if0.mem_din;
        if0.mem_dout <= ram0[if0.mem_addr[7:0]];
        if (if1.mem_we) ram1[if1.mem_addr[7:0]] <= if1.mem_din;
        if1.mem_dout <= ram1[if1.mem_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit a_req; bit a_we; bit a_lock; logic [15:0] a_addr; logic [15:0] a_wdata;
        bit b_req; bit b_we; bit b_lock; logic [15:0] b_addr; logic [15:0] b_wdata;
        bit e_a_gnt; bit e_b_gnt; bit e_we; logic [15:0] e_addr; logic [15:0] e_din;
        bit e_a_rv; bit e_b_rv; logic [15:0] e_rdata; bit e_err;
    } vec_t;

    function automatic vec_t mk(bit r,
        bit ar, bit aw, bit al, logic [15:0] aa, logic [15:0] ad,
        bit br, bit bw, bit bl, logic [15:0] ba, logic [15:0] bd,
        bit eag, bit ebg, bit ewe, logic [15:0] ema, logic [15:0] emd,
        bit earv, bit ebrv, logic [15:0] erd, bit eer);
        vec_t v;
        v.rst_n = r;
        v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
        v.e_a_gnt = eag; v.e_b_gnt = ebg; v.e_we = ewe; v.e_addr = ema; v.e_din = emd;
        v.e_a_rv = earv; v.e_b_rv = ebrv; v.e_rdata = erd; v.e_err = eer;
        return v;
    endfunction

    task automatic drive0(input bit r, input bit ar, input bit aw, input bit al,
                          input logic [15:0] aa, input logic [15:0] ad,
                          input bit br, input bit bw, input bit bl,
                          input logic [15:0] ba, input logic [15:0] bd);
        rst0 = r;
        if0.a_req = ar; if0.a_we = aw; if0.a_lock = al; if0.a_addr = aa; if0.a_wdata = ad;
        if0.b_req = br; if0.b_we = bw; if0.b_lock = bl; if0.b_addr = ba; if0.b_wdata = bd;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive0(v.rst_n, v.a_req, v.a_we, v.a_lock, v.a_addr, v.a_wdata,
               v.b_req, v.b_we, v.b_lock, v.b_addr, v.b_wdata);
        @(negedge clk);
        chk($sformatf("vec%0d a_gnt", idx), 32'(if0.a_gnt), 32'(v.e_a_gnt));
        chk($sformatf("vec%0d b_gnt", idx), 32'(if0.b_gnt), 32'(v.e_b_gnt));
        chk($sformatf("vec%0d mem_we", idx), 32'(if0.mem_we), 32'(v.e_we));
        chk($sformatf("vec%0d mem_addr", idx), 32'(if0.mem_addr), 32'(v.e_addr));
        chk($sformatf("vec%0d mem_din", idx), 32'(if0.mem_din), 32'(v.e_din));
        chk($sformatf("vec%0d a_rvalid", idx), 32'(if0.a_rvalid), 32'(v.e_a_rv));
        chk($sformatf("vec%0d b_rvalid", idx), 32'(if0.b_rvalid), 32'(v.e_b_rv));
        chk($sformatf("vec%0d lock_err", idx), 32'(if0.lock_err), 32'(v.e_err));
        if (v.e_a_rv) chk($sformatf("vec%0d a_rdata", idx), 32'(if0.a_rdata), 32'(v.e_rdata));
        if (v.e_b_rv) chk($sformatf("vec%0d b_rdata", idx), 32'(if0.b_rdata), 32'(v.e_rdata));
    endtask

    // Reference model state for the randomized phase.
    int          m_own;     // -1: nobody holds the lock, else port index
    int          m_held;    // locked cycles completed by the owner
    int          m_last;    // port granted most recently
    bit          m_ban [2];
    bit          m_rv [2];
    logic [15:0] m_rd [2];
    bit          m_err;
    logic [15:0] mref [256];

    vec_t vecs[$];

    initial begin
        bit          r;
        bit          req [2];
        bit          we [2];
        bit          lk [2];
        logic [15:0] addr [2];
        logic [15:0] wd [2];
        int          win;

        drive0(1'b0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
        if1.a_req = 0; if1.a_we = 0; if1.a_lock = 0; if1.a_addr = 0; if1.a_wdata = 0;
        if1.b_req = 0; if1.b_we = 0; if1.b_lock = 0; if1.b_addr = 0; if1.b_wdata = 0;

        // ---- directed table (round-robin DUT, LOCK_MAX=4) ----
        // reset with both requesting, then round-robin reads of 64/65
        vecs.push_back(mk(0, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        vecs.push_back(mk(0, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 1,0,0,16'h40,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 0,1,0,16'h41,0, 1,0,16'hA040,0));
        vecs.push_back(mk(1, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 1,0,0,16'h40,0, 0,1,16'hA041,0));
        vecs.push_back(mk(1, 1,0,0,16'h40,0, 1,0,0,16'h41,0, 0,1,0,16'h41,0, 1,0,16'hA040,0));
        // read-modify-write of 0x40 under lock while B waits
        vecs.push_back(mk(1, 1,0,1,16'h40,0, 1,0,0,16'h40,0, 1,0,0,16'h40,0, 0,1,16'hA041,0));
        vecs.push_back(mk(1, 1,1,0,16'h40,16'hA041, 1,0,0,16'h40,0, 1,0,1,16'h40,16'hA041, 1,0,16'hA040,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 1,0,0,16'h40,0, 0,1,0,16'h40,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,1,16'hA041,0));
        // lock timeout: A locks and keeps lock=1
        vecs.push_back(mk(1, 1,0,1,16'h20,0, 1,0,0,16'h21,0, 1,0,0,16'h20,0, 0,0,16'h0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 1,0,1,16'h20,0, 1,0,0,16'h21,0, 1,0,0,16'h20,0, 1,0,16'hA020,0));
        vecs.push_back(mk(1, 1,0,1,16'h20,0, 1,0,0,16'h21,0, 0,1,0,16'h21,0, 1,0,16'hA020,1));
        vecs.push_back(mk(1, 1,0,1,16'h20,0, 1,0,0,16'h21,0, 1,0,0,16'h20,0, 0,1,16'hA021,0));
        vecs.push_back(mk(1, 1,0,1,16'h20,0, 1,0,0,16'h21,0, 0,1,0,16'h21,0, 1,0,16'hA020,0));
        // a_lock low clears the ban; A can lock again and idle while holding it
        vecs.push_back(mk(1, 1,0,0,16'h20,0, 0,0,0,16'h0,0, 1,0,0,16'h20,0, 0,1,16'hA021,0));
        vecs.push_back(mk(1, 1,0,1,16'h20,0, 0,0,0,16'h0,0, 1,0,0,16'h20,0, 1,0,16'hA020,0));
        vecs.push_back(mk(1, 0,0,1,16'h0,0, 1,0,0,16'h21,0, 0,0,0,16'h0,0, 1,0,16'hA020,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 1,0,0,16'h21,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 1,0,0,16'h21,0, 0,1,0,16'h21,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,1,16'hA021,0));
        // write then read-back, then reset right after a read
        vecs.push_back(mk(1, 1,1,0,16'h10,16'hBEEF, 0,0,0,16'h0,0, 1,0,1,16'h10,16'hBEEF, 0,0,16'h0,0));
        vecs.push_back(mk(1, 1,0,0,16'h10,0, 0,0,0,16'h0,0, 1,0,0,16'h10,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 1,0,0,16'h11,0, 0,0,0,16'h0,0, 1,0,0,16'h11,0, 1,0,16'hBEEF,0));
        vecs.push_back(mk(0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        // reset while A holds the lock: lock dropped, no lock_err
        vecs.push_back(mk(1, 1,0,1,16'h30,0, 1,0,0,16'h31,0, 1,0,0,16'h30,0, 0,0,16'h0,0));
        vecs.push_back(mk(0, 1,0,1,16'h30,0, 1,0,0,16'h31,0, 0,0,0,16'h0,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 1,0,0,16'h31,0, 0,1,0,16'h31,0, 0,0,16'h0,0));
        vecs.push_back(mk(1, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,1,16'hA031,0));

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // ---- fixed priority DUT: A starves B until a_req drops ----
        @(posedge clk); #1;
        rst1 = 1'b1;
        if1.a_req = 1; if1.a_addr = 16'h50;
        if1.b_req = 1; if1.b_addr = 16'h51;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("fp%0d a_gnt", i), 32'(if1.a_gnt), 32'd1);
            chk($sformatf("fp%0d b_gnt", i), 32'(if1.b_gnt), 32'd0);
            chk($sformatf("fp%0d a_rvalid", i), 32'(if1.a_rvalid), 32'(i > 0));
            if (i > 0) chk($sformatf("fp%0d a_rdata", i), 32'(if1.a_rdata), 32'h0000A050);
            @(posedge clk); #1;
        end
        if1.a_req = 0;
        @(negedge clk);
        chk("fp b_gnt after a drops", 32'(if1.b_gnt), 32'd1);
        chk("fp mem_addr after a drops", 32'(if1.mem_addr), 32'h51);
        @(posedge clk); #1;
        if1.b_req = 0;
        @(negedge clk);
        chk("fp b_rvalid", 32'(if1.b_rvalid), 32'd1);
        chk("fp b_rdata", 32'(if1.b_rdata), 32'h0000A051);

        // ---- randomized phase against the reference model ----
        for (int i = 0; i < 256; i++) mref[i] = 16'hA000 + 16'(i);
        for (int p = 0; p < 2; p++) lk[p] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            r = (cyc == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            for (int p = 0; p < 2; p++) begin
                req[p]  = ($urandom_range(0, 3) != 0);
                we[p]   = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) lk[p] = ~lk[p];
                addr[p] = 16'(128 + $urandom_range(0, 7));
                wd[p]   = 16'($urandom);
            end
            drive0(r, req[0], we[0], lk[0], addr[0], wd[0], req[1], we[1], lk[1], addr[1], wd[1]);
            @(negedge clk);

            if (cyc == 0) begin
                win = -1;
            end else begin
                if (!r) win = -1;
                else if (m_own >= 0) win = req[m_own] ? m_own : -1;
                else if (req[0] && req[1]) win = 1 - m_last;
                else if (req[0]) win = 0;
                else if (req[1]) win = 1;
                else win = -1;

                chk($sformatf("rnd%0d a_gnt", cyc), 32'(if0.a_gnt), 32'(win == 0));
                chk($sformatf("rnd%0d b_gnt", cyc), 32'(if0.b_gnt), 32'(win == 1));
                chk($sformatf("rnd%0d mem_we", cyc), 32'(if0.mem_we), (win >= 0) ? 32'(we[win]) : 32'd0);
                chk($sformatf("rnd%0d mem_addr", cyc), 32'(if0.mem_addr), (win >= 0) ? 32'(addr[win]) : 32'd0);
                chk($sformatf("rnd%0d mem_din", cyc), 32'(if0.mem_din), (win >= 0) ? 32'(wd[win]) : 32'd0);
                chk($sformatf("rnd%0d a_rvalid", cyc), 32'(if0.a_rvalid), 32'(m_rv[0] && r));
                chk($sformatf("rnd%0d b_rvalid", cyc), 32'(if0.b_rvalid), 32'(m_rv[1] && r));
                chk($sformatf("rnd%0d lock_err", cyc), 32'(if0.lock_err), 32'(m_err));
                if (m_rv[0] && r) chk($sformatf("rnd%0d a_rdata", cyc), 32'(if0.a_rdata), 32'(m_rd[0]));
                if (m_rv[1] && r) chk($sformatf("rnd%0d b_rdata", cyc), 32'(if0.b_rdata), 32'(m_rd[1]));
            end

            // advance the model across the coming clock edge
            if (!r) begin
                m_own = -1; m_held = 0; m_last = 1; m_err = 1'b0;
                m_ban[0] = 1'b0; m_ban[1] = 1'b0;
                m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            end else begin
                m_err = 1'b0;
                for (int p = 0; p < 2; p++) m_rv[p] = (win == p) && !we[p];
                if (win >= 0) begin
                    if (we[win]) mref[addr[win][7:0]] = wd[win];
                    else m_rd[win] = mref[addr[win][7:0]];
                    m_last = win;
                end
                if (m_own >= 0) begin
                    if (!lk[m_own]) begin
                        m_own = -1;
                    end else if (m_held + 1 == LOCK_MAX0) begin
                        m_err = 1'b1;
                        m_ban[m_own] = 1'b1;
                        m_last = m_own;
                        m_own = -1;
                    end else begin
                        m_held++;
                    end
                end else if (win >= 0 && lk[win] && !m_ban[win]) begin
                    m_own = win;
                    m_held = 0;
                end
                for (int p = 0; p < 2; p++) if (!lk[p]) m_ban[p] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
